mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequences and shares the single unified instruction/data memory of the multi-cycle processor between two requesters.
  - Requester 0: the CPU (FETCH/MEMRD/MEMWR accesses).
  - Requester 1: a program loader / DMA port.
- Presents one request/ack memory interface with variable latency and a watchdog timeout.
- Returns a one-cycle done pulse, plus an error flag on timeout, to the served requester.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 15, maximum ACCESS cycles waiting for mem_ack before abort (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req  in  2  per-requester request (bit 0 CPU, bit 1 loader)
- we  in  2  per-requester write enable
- addr  in  2*AW  requester i at [i*AW +: AW]
- wdata  in  2*DW  requester i at [i*DW +: DW]
- rdata  out  DW  read data, shared; valid when any done bit is high
- done  out  2  one-cycle completion pulse to the served requester
- err  out  1  high with done when the access timed out
- owner  out  1  index of the currently/last granted requester
- mem_req  out  1  memory request, held through the access
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle

Behaviour:
- All outputs registered.
- Reset (synchronous, any state):
  - state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - rdata=0, done=0, err=0, timeout counter=0.
  - owner=1, so the CPU wins the first contention.
  - An in-flight memory access is abandoned.
- States:
  - IDLE:
    - Sample req. If none, stay.
    - Exactly one set: grant it.
    - Both set: grant the requester ≠ owner (round-robin).
    - On grant: latch owner, mem_addr, mem_wdata, mem_we from the winner; set mem_req=1; clear counter; go ACCESS.
  - ACCESS:
    - mem_req, mem_we, mem_addr, mem_wdata held stable.
    - mem_ack=1: rdata<=mem_rdata (rdata<=0 on writes); err<=0; go RESP.
    - Else, counter==TIMEOUT-1: rdata<=0; err<=1; go RESP.
    - Else: counter+1.
    - mem_ack wins over a simultaneous timeout expiry.
    - Leaving ACCESS: mem_req<=0, mem_we<=0.
  - RESP:
    - done[owner]=1 for exactly this cycle; rdata and err valid.
    - req is ignored in this cycle; go IDLE.
    - Leaving RESP: done<=0, err<=0.
- Requester contract:
  - Hold req, we, addr and wdata stable from assertion until the clock edge where done is seen.
  - At that edge, either drop req or present the next transaction. A still-high req is a new transaction.
- Latency:
  - req sampled at edge k.
  - mem_req high in cycle k+1.
  - Ack in cycle m (m≥k+1) gives done in cycle m+1.
  - Minimum 3 cycles from req to done; back-to-back throughput is one access per 3 cycles.
- Fairness: under continuous contention, grants alternate 0,1,0,1…; a lone requester is granted every access.
- mem_ack outside ACCESS is ignored.
- Changes to req, we, addr or wdata during ACCESS/RESP do not affect the access in flight.
- The non-owner requester's done bit stays 0 always.

Decomposition:
- Shared package (mem_arb_pkg):
  - State encoding: IDLE=2'b00, ACCESS=2'b01, RESP=2'b10.
  - Requester index constants: REQ_CPU=0, REQ_LDR=1.
  - Default TIMEOUT.
- One natural sub-module, rr_pick2: combinational 2-way round-robin picker. Inputs req[1:0] and last; outputs valid and winner index.
- The FSM, timeout counter and datapath latches live in mem_arbiter.

Test Plan:
- Single CPU read:
  - Stimulus: req=01, we=0, addr0=0x00000010; memory acks 2 cycles after mem_req with rdata 0xDEADBEEF.
  - Required: mem_addr=0x10; done=01 one cycle after ack; rdata=0xDEADBEEF; err=0; owner=0.
- Loader write:
  - Stimulus: req=10, we=10, addr1=0x40, wdata1=0x12345678; zero-wait ack.
  - Required: mem_we=1, mem_wdata=0x12345678; done=10 exactly 3 cycles after req; rdata=0.
- Contention after reset:
  - Stimulus: req=11 held for 4 transactions.
  - Required: grant order CPU, loader, CPU, loader; done alternates 01,10,01,10.
- Timeout:
  - Stimulus: CPU read with mem_ack never asserted, TIMEOUT=15.
  - Required: mem_req high 15 cycles, then done=01, err=1, rdata=0; the next request proceeds normally.
- Ack/timeout collision:
  - Stimulus: mem_ack=1 on the 15th ACCESS cycle with rdata 0xA5A5A5A5.
  - Required: err=0, rdata=0xA5A5A5A5.
- Mid-access reset:
  - Stimulus: reset asserted during ACCESS.
  - Required: next cycle mem_req=0, done=0, state IDLE; a later req=11 grants the CPU first; a late mem_ack is ignored.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory arbiter: FSM state encoding,
// requester index constants and the default watchdog length.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } arb_state_t;

    localparam int REQ_CPU = 0;
    localparam int REQ_LDR = 1;

    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: when both requesters ask, the one that was
// not served last wins; a lone requester always wins.
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_winner
);

    // Pick a winner from the request pair, favouring the non-last requester on contention
    always_comb begin
        o_valid  = |i_req;
        o_winner = 1'b0;
        if (i_req == 2'b11) begin
            o_winner = ~i_last;
        end else if (i_req[1]) begin
            o_winner = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the processor's single instruction/data memory between the CPU and
// the program loader. One access at a time: IDLE picks a requester, ACCESS
// holds the memory request until ack or watchdog expiry, RESP returns a
// one-cycle done pulse (with err on timeout) to the served requester.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [1:0]      i_req,
    input  logic [1:0]      i_we,
    input  logic [2*AW-1:0] i_addr,
    input  logic [2*DW-1:0] i_wdata,
    output logic [DW-1:0]   o_rdata,
    output logic [1:0]      o_done,
    output logic            o_err,
    output logic            o_owner,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW-1:0]   o_mem_wdata,
    input  logic [DW-1:0]   i_mem_rdata,
    input  logic            i_mem_ack
);

    // Counter only needs to reach TIMEOUT-1; keep at least one bit for TIMEOUT=1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_t    r_state;
    arb_state_t    w_next_state;

    logic [CW-1:0] r_cnt;
    logic          r_owner;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_rdata;
    logic [1:0]    r_done;
    logic          r_err;

    logic [CW-1:0] w_cnt;
    logic          w_owner;
    logic          w_mem_req;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;
    logic [DW-1:0] w_rdata;
    logic [1:0]    w_done;
    logic          w_err;

    logic          w_pick_valid;
    logic          w_pick_winner;

    rr_pick2 u_pick (
        .i_req    (i_req),
        .i_last   (r_owner),
        .o_valid  (w_pick_valid),
        .o_winner (w_pick_winner)
    );

    // State register; reset abandons any in-flight access
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath decisions; everything holds unless a transition changes it
    always_comb begin
        w_next_state = r_state;
        w_cnt        = r_cnt;
        w_owner      = r_owner;
        w_mem_req    = r_mem_req;
        w_mem_we     = r_mem_we;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        w_rdata      = r_rdata;
        w_done       = 2'b00;
        w_err        = r_err;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_owner   = w_pick_winner;
                    w_mem_req = 1'b1;
                    w_cnt     = '0;
                    if (w_pick_winner) begin
                        w_mem_we    = i_we[REQ_LDR];
                        w_mem_addr  = i_addr[REQ_LDR*AW +: AW];
                        w_mem_wdata = i_wdata[REQ_LDR*DW +: DW];
                    end else begin
                        w_mem_we    = i_we[REQ_CPU];
                        w_mem_addr  = i_addr[REQ_CPU*AW +: AW];
                        w_mem_wdata = i_wdata[REQ_CPU*DW +: DW];
                    end
                    w_next_state = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (i_mem_ack) begin
                    w_rdata          = r_mem_we ? '0 : i_mem_rdata;
                    w_err            = 1'b0;
                    w_mem_req        = 1'b0;
                    w_mem_we         = 1'b0;
                    w_done[r_owner]  = 1'b1;
                    w_next_state     = ST_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_rdata          = '0;
                    w_err            = 1'b1;
                    w_mem_req        = 1'b0;
                    w_mem_we         = 1'b0;
                    w_done[r_owner]  = 1'b1;
                    w_next_state     = ST_RESP;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end

            ST_RESP: begin
                w_err        = 1'b0;
                w_next_state = ST_IDLE;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath registers; owner resets to the loader so the CPU wins the first contention
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt       <= '0;
            r_owner     <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_done      <= 2'b00;
            r_err       <= 1'b0;
        end else begin
            r_cnt       <= w_cnt;
            r_owner     <= w_owner;
            r_mem_req   <= w_mem_req;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_rdata     <= w_rdata;
            r_done      <= w_done;
            r_err       <= w_err;
        end
    end

    assign o_rdata     = r_rdata;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_owner     = r_owner;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule
